// File: rtl/csr_unit_pkg.sv
// Shared types and address map for the machine-mode CSR unit.
// Holds the mstatus/mtvec/mcause layouts, the access op encoding and the address decode.
package csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    typedef struct packed {
        logic [18:0] rsvd_hi;
        logic [1:0]  mpp;
        logic [2:0]  rsvd_mid;
        logic        mpie;
        logic [2:0]  rsvd_low;
        logic        mie;
        logic [2:0]  rsvd_lsb;
    } mstatus_t;

    typedef struct packed {
        logic [29:0] base;
        logic [1:0]  mode;
    } mtvec_t;

    typedef struct packed {
        logic        irq;
        logic [30:0] code;
    } mcause_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    function automatic logic csr_mapped(input logic [11:0] addr);
        logic hit;
        hit = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
            CSR_MCYCLEH, CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID, CSR_MHARTID: hit = 1'b1;
            default:                 hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter exposed as two 32-bit halves; a half write beats the increment
// and leaves the other half untouched.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [63:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 64'd0;
        end else if (we_lo) begin
            cnt[31:0] <= wdata;
        end else if (we_hi) begin
            cnt[63:32] <= wdata;
        end else if (inc) begin
            cnt <= cnt + 64'd1;
        end
    end

    assign lo = cnt[31:0];
    assign hi = cnt[63:32];

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: access decode, trap/mret state updates, interrupt
// request generation and trap vector computation.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MVENDORID   = 32'h0,
    parameter logic [31:0] MARCHID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_en,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        retire,
    input  logic        irq_ext,
    input  logic        irq_soft,
    input  logic        irq_timer,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_o
);

    csr_op_t     op;
    mstatus_t    mstatus_q;
    mtvec_t      mtvec_q;
    mcause_t     mcause_q;
    logic [31:0] mie_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mtval_q;
    logic [31:0] mip;
    logic [31:0] pending;
    logic [31:0] mcycle_lo, mcycle_hi;
    logic [31:0] minstret_lo, minstret_hi;
    logic [31:0] wval;
    logic        wr_attempt;
    logic        do_wr;

    assign op  = csr_op_t'(csr_op);
    assign mip = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_soft, 3'd0};

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_q;
            CSR_MIE:       csr_rdata = mie_q;
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MTVAL:     csr_rdata = mtval_q;
            CSR_MIP:       csr_rdata = mip;
            CSR_MCYCLE:    csr_rdata = mcycle_lo;
            CSR_MCYCLEH:   csr_rdata = mcycle_hi;
            CSR_MINSTRET:  csr_rdata = minstret_lo;
            CSR_MINSTRETH: csr_rdata = minstret_hi;
            CSR_MVENDORID: csr_rdata = MVENDORID;
            CSR_MARCHID:   csr_rdata = MARCHID;
            CSR_MHARTID:   csr_rdata = HART_ID;
            default:       csr_rdata = 32'd0;
        endcase
    end

    // Set/clear with an all-zero mask is a pure read and must not count as a write.
    always_comb begin
        wr_attempt = 1'b0;
        wval       = csr_rdata;
        case (op)
            CSR_OP_RW: begin
                wr_attempt = csr_en;
                wval       = csr_wdata;
            end
            CSR_OP_RS: begin
                wr_attempt = csr_en && (csr_wdata != 32'd0);
                wval       = csr_rdata | csr_wdata;
            end
            CSR_OP_RC: begin
                wr_attempt = csr_en && (csr_wdata != 32'd0);
                wval       = csr_rdata & ~csr_wdata;
            end
            default: begin
                wr_attempt = 1'b0;
                wval       = csr_rdata;
            end
        endcase
    end

    assign csr_illegal = csr_en && (!csr_mapped(csr_addr) ||
                                    (wr_attempt && (csr_addr[11:10] == 2'b11)));
    assign do_wr       = wr_attempt && !csr_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= mstatus_t'(MSTATUS_RESET);
            mtvec_q    <= mtvec_t'(MTVEC_RESET);
            mie_q      <= 32'd0;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= mcause_t'(32'd0);
            mtval_q    <= 32'd0;
        end else begin
            // A trap owns mstatus/mepc/mcause/mtval this cycle; mret owns mstatus.
            if (trap_en) begin
                mepc_q         <= trap_epc & ~32'h3;
                mcause_q       <= mcause_t'(trap_cause);
                mtval_q        <= trap_tval;
                mstatus_q.mpie <= mstatus_q.mie;
                mstatus_q.mie  <= 1'b0;
            end else begin
                if (mret) begin
                    mstatus_q.mie  <= mstatus_q.mpie;
                    mstatus_q.mpie <= 1'b1;
                end else if (do_wr && csr_addr == CSR_MSTATUS) begin
                    mstatus_q.mie  <= wval[3];
                    mstatus_q.mpie <= wval[7];
                end
                if (do_wr && csr_addr == CSR_MEPC)   mepc_q   <= wval & ~32'h3;
                if (do_wr && csr_addr == CSR_MCAUSE) mcause_q <= mcause_t'(wval);
                if (do_wr && csr_addr == CSR_MTVAL)  mtval_q  <= wval;
            end
            if (do_wr && csr_addr == CSR_MIE)      mie_q      <= wval & MIE_WMASK;
            if (do_wr && csr_addr == CSR_MTVEC)    mtvec_q    <= mtvec_t'(wval & 32'hFFFF_FFFD);
            if (do_wr && csr_addr == CSR_MSCRATCH) mscratch_q <= wval;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .we_lo (do_wr && csr_addr == CSR_MCYCLE),
        .we_hi (do_wr && csr_addr == CSR_MCYCLEH),
        .wdata (wval),
        .lo    (mcycle_lo),
        .hi    (mcycle_hi)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .we_lo (do_wr && csr_addr == CSR_MINSTRET),
        .we_hi (do_wr && csr_addr == CSR_MINSTRETH),
        .wdata (wval),
        .lo    (minstret_lo),
        .hi    (minstret_hi)
    );

    assign pending = mie_q & mip;
    assign irq_req = mstatus_q.mie && (pending != 32'd0);

    always_comb begin
        irq_cause = 32'd0;
        if (irq_req) begin
            if (pending[11])     irq_cause = 32'h8000_000B;
            else if (pending[3]) irq_cause = 32'h8000_0003;
            else                 irq_cause = 32'h8000_0007;
        end
    end

    always_comb begin
        trap_vector = {mtvec_q.base, 2'b00};
        if (mtvec_q.mode == 2'b01 && trap_cause[31]) begin
            trap_vector = {mtvec_q.base, 2'b00} + {trap_cause[29:0], 2'b00};
        end
    end

    assign mepc_o = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: reset, access ops, trap/mret, interrupts,
// vectoring, counters, illegal accesses and same-cycle priority.
module tb_csr_unit;

    localparam logic [31:0] P_HART   = 32'h0000_0005;
    localparam logic [31:0] P_VENDOR = 32'h0000_1234;
    localparam logic [31:0] P_ARCH   = 32'h0000_0007;
    localparam logic [31:0] P_MTVEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_en;
    logic [31:0] trap_cause, trap_epc, trap_tval;
    logic        mret, retire;
    logic        irq_ext, irq_soft, irq_timer;
    logic        irq_req;
    logic [31:0] irq_cause, trap_vector, mepc_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd;
    logic        ill;

    csr_unit #(
        .HART_ID     (P_HART),
        .MVENDORID   (P_VENDOR),
        .MARCHID     (P_ARCH),
        .MTVEC_RESET (P_MTVEC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_en      (csr_en),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .trap_en     (trap_en),
        .trap_cause  (trap_cause),
        .trap_epc    (trap_epc),
        .trap_tval   (trap_tval),
        .mret        (mret),
        .retire      (retire),
        .irq_ext     (irq_ext),
        .irq_soft    (irq_soft),
        .irq_timer   (irq_timer),
        .irq_req     (irq_req),
        .irq_cause   (irq_cause),
        .trap_vector (trap_vector),
        .mepc_o      (mepc_o)
    );

    always #5 clk = ~clk;

    // One CSR access occupying exactly one clock cycle; outputs sampled mid-cycle.
    task automatic do_access(input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wd, output logic [31:0] r, output logic il);
        @(negedge clk);
        csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
        #1;
        r  = csr_rdata;
        il = csr_illegal;
        @(posedge clk);
        #1;
        csr_en = 1'b0; csr_op = 2'b00; csr_wdata = 32'd0;
    endtask

    task automatic pulse_event(input logic t, input logic m, input logic [31:0] cause,
                               input logic [31:0] epc, input logic [31:0] tval);
        @(negedge clk);
        trap_en = t; mret = m; trap_cause = cause; trap_epc = epc; trap_tval = tval;
        @(posedge clk);
        #1;
        trap_en = 1'b0; mret = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL reset_irq_req: got %b want 0", irq_req); end
        n_cmp++; if (irq_cause !== 32'd0) begin n_bad++; $display("FAIL reset_irq_cause: got %h want 0", irq_cause); end
        n_cmp++; if (mepc_o !== 32'd0) begin n_bad++; $display("FAIL reset_mepc_o: got %h want 0", mepc_o); end
        n_cmp++; if (csr_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", csr_illegal); end
        csr_en = 1'b1; csr_op = 2'b00; csr_addr = 12'hB00;
        #1;
        n_cmp++; if (csr_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_mcycle0: got %h want 0", csr_rdata); end
        @(posedge clk);
        #1;
        csr_en = 1'b0;
        do_access(2'b00, 12'hB00, 32'd0, rd, ill);
        n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL reset_mcycle1: got %h want 1", rd); end
        do_access(2'b00, 12'hB00, 32'd0, rd, ill);
        n_cmp++; if (rd !== 32'd2) begin n_bad++; $display("FAIL reset_mcycle2: got %h want 2", rd); end
        do_access(2'b00, 12'h300, 32'd0, rd, ill);
        n_cmp++; if (rd !== 32'h1800) begin n_bad++; $display("FAIL reset_mstatus: got %h want 1800", rd); end
        do_access(2'b00, 12'h305, 32'd0, rd, ill);
        n_cmp++; if (rd !== P_MTVEC) begin n_bad++; $display("FAIL reset_mtvec: got %h want %h", rd, P_MTVEC); end
    endtask

    task automatic test_ops();
        do_access(2'b01, 12'h304, 32'h888, rd, ill);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL rw_old: got %h want 0", rd); end
        do_access(2'b10, 12'h304, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h888) begin n_bad++; $display("FAIL rs0_rdata: got %h want 888", rd); end
        do_access(2'b11, 12'h304, 32'h8, rd, ill);
        n_cmp++; if (rd !== 32'h888) begin n_bad++; $display("FAIL rc_old: got %h want 888", rd); end
        do_access(2'b00, 12'h304, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h880) begin n_bad++; $display("FAIL rc_new: got %h want 880", rd); end
        do_access(2'b01, 12'h304, 32'hFFFF_FFFF, rd, ill);
        do_access(2'b00, 12'h304, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h888) begin n_bad++; $display("FAIL mie_mask: got %h want 888", rd); end
        do_access(2'b01, 12'h341, 32'h107, rd, ill);
        do_access(2'b00, 12'h341, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h104) begin n_bad++; $display("FAIL mepc_align: got %h want 104", rd); end
        n_cmp++; if (mepc_o !== 32'h104) begin n_bad++; $display("FAIL mepc_o: got %h want 104", mepc_o); end
    endtask

    task automatic test_trap_mret();
        do_access(2'b01, 12'h300, 32'h8, rd, ill);
        do_access(2'b00, 12'h300, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h1808) begin n_bad++; $display("FAIL mie_set: got %h want 1808", rd); end
        pulse_event(1'b1, 1'b0, 32'h8000_000B, 32'h103, 32'h55);
        do_access(2'b00, 12'h341, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h100) begin n_bad++; $display("FAIL trap_mepc: got %h want 100", rd); end
        n_cmp++; if (mepc_o !== 32'h100) begin n_bad++; $display("FAIL trap_mepc_o: got %h want 100", mepc_o); end
        do_access(2'b00, 12'h300, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h1880) begin n_bad++; $display("FAIL trap_mstatus: got %h want 1880", rd); end
        do_access(2'b00, 12'h342, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h8000_000B) begin n_bad++; $display("FAIL trap_mcause: got %h want 8000000b", rd); end
        do_access(2'b00, 12'h343, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h55) begin n_bad++; $display("FAIL trap_mtval: got %h want 55", rd); end
        pulse_event(1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
        do_access(2'b00, 12'h300, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h1888) begin n_bad++; $display("FAIL mret_mstatus: got %h want 1888", rd); end
    endtask

    task automatic test_irq();
        do_access(2'b01, 12'h304, 32'h888, rd, ill);
        @(negedge clk);
        irq_ext = 1'b1; irq_timer = 1'b1;
        #1;
        n_cmp++; if (irq_req !== 1'b1) begin n_bad++; $display("FAIL irq_req_ext: got %b want 1", irq_req); end
        n_cmp++; if (irq_cause !== 32'h8000_000B) begin n_bad++; $display("FAIL irq_cause_ext: got %h want 8000000b", irq_cause); end
        irq_ext = 1'b0; irq_soft = 1'b1;
        #1;
        n_cmp++; if (irq_cause !== 32'h8000_0003) begin n_bad++; $display("FAIL irq_cause_soft: got %h want 80000003", irq_cause); end
        do_access(2'b00, 12'h344, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h88) begin n_bad++; $display("FAIL mip_read: got %h want 88", rd); end
        @(negedge clk);
        irq_soft = 1'b0;
        #1;
        n_cmp++; if (irq_cause !== 32'h8000_0007) begin n_bad++; $display("FAIL irq_cause_timer: got %h want 80000007", irq_cause); end
        do_access(2'b11, 12'h300, 32'h8, rd, ill);
        #1;
        n_cmp++; if (irq_req !== 1'b0) begin n_bad++; $display("FAIL irq_gated: got %b want 0", irq_req); end
        n_cmp++; if (irq_cause !== 32'd0) begin n_bad++; $display("FAIL irq_cause_gated: got %h want 0", irq_cause); end
        irq_timer = 1'b0;
    endtask

    task automatic test_vector();
        do_access(2'b01, 12'h305, 32'h1003, rd, ill);
        do_access(2'b00, 12'h305, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h1001) begin n_bad++; $display("FAIL mtvec_mode: got %h want 1001", rd); end
        @(negedge clk);
        trap_cause = 32'h8000_0007;
        #1;
        n_cmp++; if (trap_vector !== 32'h101C) begin n_bad++; $display("FAIL vec_irq: got %h want 101c", trap_vector); end
        trap_cause = 32'h2;
        #1;
        n_cmp++; if (trap_vector !== 32'h1000) begin n_bad++; $display("FAIL vec_exc: got %h want 1000", trap_vector); end
    endtask

    task automatic test_counters();
        @(negedge clk);
        retire = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        retire = 1'b0;
        do_access(2'b00, 12'hB02, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'd3) begin n_bad++; $display("FAIL minstret: got %h want 3", rd); end
        do_access(2'b01, 12'hB80, 32'hFFFF_FFFF, rd, ill);
        do_access(2'b01, 12'hB00, 32'hFFFF_FFFF, rd, ill);
        do_access(2'b00, 12'hB00, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mcycle_max: got %h want ffffffff", rd); end
        do_access(2'b00, 12'hB80, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL mcycleh_wrap: got %h want 0", rd); end
        do_access(2'b00, 12'hB00, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL mcycle_wrap: got %h want 1", rd); end
    endtask

    task automatic test_illegal();
        do_access(2'b01, 12'hF12, 32'h5, rd, ill);
        n_cmp++; if (ill !== 1'b1) begin n_bad++; $display("FAIL ill_ro_write: got %b want 1", ill); end
        do_access(2'b00, 12'hF12, 32'h0, rd, ill);
        n_cmp++; if (rd !== P_ARCH || ill !== 1'b0) begin n_bad++; $display("FAIL marchid_read: got %h/%b want %h/0", rd, ill, P_ARCH); end
        do_access(2'b00, 12'hF14, 32'h0, rd, ill);
        n_cmp++; if (rd !== P_HART) begin n_bad++; $display("FAIL mhartid: got %h want %h", rd, P_HART); end
        do_access(2'b00, 12'h7C0, 32'h0, rd, ill);
        n_cmp++; if (ill !== 1'b1) begin n_bad++; $display("FAIL ill_unmapped: got %b want 1", ill); end
    endtask

    task automatic test_priority();
        do_access(2'b01, 12'h300, 32'h80, rd, ill);
        @(negedge clk);
        trap_en = 1'b1; mret = 1'b1; trap_cause = 32'h2; trap_epc = 32'h200; trap_tval = 32'h0;
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h342; csr_wdata = 32'h77;
        @(posedge clk);
        #1;
        trap_en = 1'b0; mret = 1'b0; csr_en = 1'b0; csr_op = 2'b00;
        do_access(2'b00, 12'h300, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h1800) begin n_bad++; $display("FAIL prio_mstatus: got %h want 1800", rd); end
        do_access(2'b00, 12'h342, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL prio_mcause: got %h want 2", rd); end
        do_access(2'b00, 12'h341, 32'h0, rd, ill);
        n_cmp++; if (rd !== 32'h200) begin n_bad++; $display("FAIL prio_mepc: got %h want 200", rd); end
    endtask

    initial begin
        rst = 1'b1; csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
        trap_en = 1'b0; trap_cause = 32'h0; trap_epc = 32'h0; trap_tval = 32'h0;
        mret = 1'b0; retire = 1'b0; irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_ops();
        test_trap_mret();
        test_irq();
        test_vector();
        test_counters();
        test_illegal();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
